// File: rtl/bus_pkg.sv
// Shared types and constants for the 8-slave bus master.
// Slave count, index width, FSM state encoding and a one-hot helper.
package bus_pkg;

    localparam int SLAVE_NUM   = 8;
    localparam int SLAVE_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_mst_state_t;

    // Binary slave index to one-hot chip-select vector.
    function automatic logic [SLAVE_NUM-1:0] idx_to_onehot(
        input logic [SLAVE_IDX_W-1:0] idx
    );
        logic [SLAVE_NUM-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Slave index field -> one-hot chip select plus mapped flag.
// Unmapped slaves (SLAVE_EN bit clear) get no chip select.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter logic [SLAVE_NUM-1:0] SLAVE_EN = 8'hFF
) (
    input  logic [SLAVE_IDX_W-1:0] idx_i,
    output logic [SLAVE_NUM-1:0]   cs_o,
    output logic                   mapped_o
);

    // Mapped check and one-hot expansion of the slave index.
    always_comb begin
        mapped_o = SLAVE_EN[idx_i];
        cs_o     = mapped_o ? idx_to_onehot(idx_i) : '0;
    end

endmodule

// File: rtl/bus_master_ctrl.sv
// Master-side request sequencer for the shared 8-slave bus.
// One outstanding access: IDLE -> ACCESS -> RESP, with ready timeout.
module bus_master_ctrl
    import bus_pkg::*;
#(
    parameter int                   ADDR_WIDTH     = 32,
    parameter int                   DATA_BUS_WIDTH = 32,
    parameter int                   TIMEOUT        = 16,
    parameter logic [SLAVE_NUM-1:0] SLAVE_EN       = 8'hFF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      m_req_i,
    input  logic                      m_wr_i,
    input  logic [ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [DATA_BUS_WIDTH-1:0] m_wr_data_i,
    output logic                      m_busy_o,
    output logic                      m_ack_o,
    output logic                      m_err_o,
    output logic [DATA_BUS_WIDTH-1:0] m_rd_data_o,
    output logic                      s0_cs_o,
    output logic                      s1_cs_o,
    output logic                      s2_cs_o,
    output logic                      s3_cs_o,
    output logic                      s4_cs_o,
    output logic                      s5_cs_o,
    output logic                      s6_cs_o,
    output logic                      s7_cs_o,
    output logic                      s_as_o,
    output logic                      s_wr_o,
    output logic [ADDR_WIDTH-1:0]     s_addr_o,
    output logic [DATA_BUS_WIDTH-1:0] s_wr_data_o,
    input  logic [DATA_BUS_WIDTH-1:0] s_rd_data_i,
    input  logic                      s_rdy_i
);

    localparam int               CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    bus_mst_state_t            state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [SLAVE_NUM-1:0]      cs_q;
    logic                      as_q;
    logic                      wr_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_BUS_WIDTH-1:0] wdata_q;
    logic                      busy_q;
    logic                      ack_q;
    logic                      err_q;
    logic [DATA_BUS_WIDTH-1:0] rdata_q;

    logic [SLAVE_NUM-1:0]      dec_cs;
    logic                      dec_mapped;

    bus_addr_decoder #(
        .SLAVE_EN (SLAVE_EN)
    ) u_dec (
        .idx_i    (m_addr_i[ADDR_WIDTH-1 -: SLAVE_IDX_W]),
        .cs_o     (dec_cs),
        .mapped_o (dec_mapped)
    );

    // Request sequencer: all bus and master outputs come from registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_q    <= '0;
            as_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (m_req_i) begin
                        wr_q    <= m_wr_i;
                        addr_q  <= m_addr_i;
                        wdata_q <= m_wr_data_i;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        if (dec_mapped) begin
                            state_q <= ACCESS;
                            cs_q    <= dec_cs;
                            as_q    <= 1'b1;
                        end else begin
                            state_q <= RESP;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (s_rdy_i) begin
                        state_q <= RESP;
                        cs_q    <= '0;
                        as_q    <= 1'b0;
                        ack_q   <= 1'b1;
                        rdata_q <= wr_q ? '0 : s_rd_data_i;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= RESP;
                        cs_q    <= '0;
                        as_q    <= 1'b0;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    cs_q    <= '0;
                    as_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign m_busy_o    = busy_q;
    assign m_ack_o     = ack_q;
    assign m_err_o     = err_q;
    assign m_rd_data_o = rdata_q;
    assign s_as_o      = as_q;
    assign s_wr_o      = wr_q;
    assign s_addr_o    = addr_q;
    assign s_wr_data_o = wdata_q;
    assign s0_cs_o     = cs_q[0];
    assign s1_cs_o     = cs_q[1];
    assign s2_cs_o     = cs_q[2];
    assign s3_cs_o     = cs_q[3];
    assign s4_cs_o     = cs_q[4];
    assign s5_cs_o     = cs_q[5];
    assign s6_cs_o     = cs_q[6];
    assign s7_cs_o     = cs_q[7];

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Bench for bus_master_ctrl: fully mapped instance plus a 8'h7F instance.
// Expected responses queued at request time, popped on ack/err.
module tb_bus_master_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m_req_i, m_wr_i;
    logic [31:0] m_addr_i, m_wr_data_i;
    logic [31:0] s_rd_data_i;
    logic        s_rdy_i;

    logic        m_busy_o, m_ack_o, m_err_o;
    logic [31:0] m_rd_data_o;
    logic [7:0]  cs_a;
    logic        s_as_o, s_wr_o;
    logic [31:0] s_addr_o, s_wr_data_o;

    logic        m_busy_u, m_ack_u, m_err_u;
    logic [31:0] m_rd_data_u;
    logic [7:0]  cs_u;
    logic        s_as_u, s_wr_u;
    logic [31:0] s_addr_u, s_wr_data_u;

    bus_master_ctrl #(
        .ADDR_WIDTH(32), .DATA_BUS_WIDTH(32), .TIMEOUT(16), .SLAVE_EN(8'hFF)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_wr_i(m_wr_i),
        .m_addr_i(m_addr_i), .m_wr_data_i(m_wr_data_i),
        .m_busy_o(m_busy_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_rd_data_o(m_rd_data_o),
        .s0_cs_o(cs_a[0]), .s1_cs_o(cs_a[1]), .s2_cs_o(cs_a[2]),
        .s3_cs_o(cs_a[3]), .s4_cs_o(cs_a[4]), .s5_cs_o(cs_a[5]),
        .s6_cs_o(cs_a[6]), .s7_cs_o(cs_a[7]),
        .s_as_o(s_as_o), .s_wr_o(s_wr_o),
        .s_addr_o(s_addr_o), .s_wr_data_o(s_wr_data_o),
        .s_rd_data_i(s_rd_data_i), .s_rdy_i(s_rdy_i)
    );

    bus_master_ctrl #(
        .ADDR_WIDTH(32), .DATA_BUS_WIDTH(32), .TIMEOUT(16), .SLAVE_EN(8'h7F)
    ) dut_u (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_wr_i(m_wr_i),
        .m_addr_i(m_addr_i), .m_wr_data_i(m_wr_data_i),
        .m_busy_o(m_busy_u), .m_ack_o(m_ack_u), .m_err_o(m_err_u),
        .m_rd_data_o(m_rd_data_u),
        .s0_cs_o(cs_u[0]), .s1_cs_o(cs_u[1]), .s2_cs_o(cs_u[2]),
        .s3_cs_o(cs_u[3]), .s4_cs_o(cs_u[4]), .s5_cs_o(cs_u[5]),
        .s6_cs_o(cs_u[6]), .s7_cs_o(cs_u[7]),
        .s_as_o(s_as_u), .s_wr_o(s_wr_u),
        .s_addr_o(s_addr_u), .s_wr_data_o(s_wr_data_u),
        .s_rd_data_i(s_rd_data_i), .s_rdy_i(s_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [7:0]  lat;
        logic [7:0]  cyc;
        logic [7:0]  cs;
        logic [31:0] rd;
        logic        chk_rd;
    } exp_t;

    typedef struct packed {
        logic        done;
        logic        ack;
        logic        err;
        logic [7:0]  lat;
        logic [7:0]  cyc;
        logic [7:0]  cs;
        logic [31:0] rd;
        logic [7:0]  multi;
        logic        wr1;
        logic [31:0] addr1;
        logic [31:0] wd1;
    } obs_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    // Slave model: ready on the rdy_after-th ACCESS cycle (0 = never).
    int          rdy_after = 0;
    int          acnt      = 0;
    logic [31:0] rd_val    = 32'h0;

    always @(negedge clk_i) begin
        if (s_as_o) begin
            acnt    = acnt + 1;
            s_rdy_i = (rdy_after > 0) && (acnt == rdy_after);
        end else begin
            acnt    = 0;
            s_rdy_i = 1'b0;
        end
        s_rd_data_i = s_rdy_i ? rd_val : 32'h0BAD_0BAD;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1);
    end

    task automatic issue(input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        m_req_i     = 1'b1;
        m_wr_i      = wr;
        m_addr_i    = a;
        m_wr_data_i = d;
        @(negedge clk_i);
        m_req_i = 1'b0;
    endtask

    // Issue one request and collect what the chosen instance does.
    task automatic run_access(input logic u, input logic wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input int budget, output obs_t o);
        o = '0;
        issue(wr, a, d);
        o.wr1   = s_wr_o;
        o.addr1 = s_addr_o;
        o.wd1   = s_wr_data_o;
        for (int i = 1; i <= budget; i++) begin
            logic [7:0]  cs;
            logic        ak, er;
            logic [31:0] rd;
            cs = u ? cs_u : cs_a;
            ak = u ? m_ack_u : m_ack_o;
            er = u ? m_err_u : m_err_o;
            rd = u ? m_rd_data_u : m_rd_data_o;
            if (cs != 8'h0) o.cyc = o.cyc + 8'd1;
            if (!$onehot0(cs)) o.multi = o.multi + 8'd1;
            o.cs = o.cs | cs;
            if (ak || er) begin
                o.done = 1'b1;
                o.lat  = 8'(i);
                o.ack  = ak;
                o.err  = er;
                o.rd   = rd;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        m_req_i = 1'b0; m_wr_i = 1'b0;
        m_addr_i = '0; m_wr_data_i = '0;
        repeat (2) @(negedge clk_i);
        n_run++;
        if ({cs_a, s_as_o, s_wr_o, m_busy_o, m_ack_o, m_err_o} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h want 0",
                     {cs_a, s_as_o, s_wr_o, m_busy_o, m_ack_o, m_err_o});
        end
        n_run++;
        if ({s_addr_o, s_wr_data_o, m_rd_data_o} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0",
                     {s_addr_o, s_wr_data_o, m_rd_data_o});
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_read_wait();
        obs_t o;
        exp_t e;
        rdy_after = 3;
        rd_val    = 32'hDEAD_BEEF;
        sb.push_back({1'b1, 1'b0, 8'd4, 8'd3, 8'h04, 32'hDEAD_BEEF, 1'b1});
        run_access(1'b0, 1'b0, 32'h4000_0010, 32'h0, 40, o);
        e = sb.pop_front();
        n_run++;
        if ({o.wr1, o.addr1} !== {1'b0, 32'h4000_0010}) begin
            n_fail++;
            $display("FAIL rd_bus: got %h want %h",
                     {o.wr1, o.addr1}, {1'b0, 32'h4000_0010});
        end
        n_run++;
        if ({o.done, o.ack, o.err, o.lat, o.cyc, o.cs} !==
            {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs}) begin
            n_fail++;
            $display("FAIL rd_resp: got %h want %h",
                     {o.done, o.ack, o.err, o.lat, o.cyc, o.cs},
                     {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs});
        end
        n_run++;
        if (e.chk_rd && o.rd !== e.rd) begin
            n_fail++;
            $display("FAIL rd_data: got %h want %h", o.rd, e.rd);
        end
        @(negedge clk_i);
        n_run++;
        if ({m_busy_o, m_ack_o, m_err_o, m_rd_data_o} !==
            {3'b000, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL rd_hold: got %h want %h",
                     {m_busy_o, m_ack_o, m_err_o, m_rd_data_o},
                     {3'b000, 32'hDEAD_BEEF});
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        rdy_after = 0;
        sb.push_back({1'b0, 1'b1, 8'd17, 8'd16, 8'h01, 32'h0, 1'b1});
        run_access(1'b0, 1'b0, 32'h0000_0100, 32'h0, 60, o);
        e = sb.pop_front();
        n_run++;
        if ({o.done, o.ack, o.err, o.lat, o.cyc, o.cs} !==
            {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs}) begin
            n_fail++;
            $display("FAIL to_resp: got %h want %h",
                     {o.done, o.ack, o.err, o.lat, o.cyc, o.cs},
                     {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs});
        end
        n_run++;
        if (o.rd !== e.rd) begin
            n_fail++;
            $display("FAIL to_data: got %h want %h", o.rd, e.rd);
        end
        @(negedge clk_i);
        n_run++;
        if ({m_busy_o, m_err_o, cs_a, s_as_o} !== 11'h0) begin
            n_fail++;
            $display("FAIL to_after: got %h want 0",
                     {m_busy_o, m_err_o, cs_a, s_as_o});
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_write_zero_wait();
        obs_t o;
        exp_t e;
        rdy_after = 1;
        rd_val    = 32'h7777_7777;
        sb.push_back({1'b1, 1'b0, 8'd2, 8'd1, 8'h80, 32'h0, 1'b0});
        run_access(1'b0, 1'b1, 32'hE000_0004, 32'h1234_5678, 40, o);
        e = sb.pop_front();
        n_run++;
        if ({o.wr1, o.addr1, o.wd1} !==
            {1'b1, 32'hE000_0004, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL wr_bus: got %h want %h",
                     {o.wr1, o.addr1, o.wd1},
                     {1'b1, 32'hE000_0004, 32'h1234_5678});
        end
        n_run++;
        if ({o.done, o.ack, o.err, o.lat, o.cyc, o.cs} !==
            {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs}) begin
            n_fail++;
            $display("FAIL wr_resp: got %h want %h",
                     {o.done, o.ack, o.err, o.lat, o.cyc, o.cs},
                     {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs});
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_unmapped();
        obs_t o;
        exp_t e;
        rdy_after = 1;
        rd_val    = 32'h1111_2222;
        sb.push_back({1'b0, 1'b1, 8'd1, 8'd0, 8'h00, 32'h0, 1'b1});
        run_access(1'b1, 1'b0, 32'hF000_0000, 32'h0, 20, o);
        e = sb.pop_front();
        n_run++;
        if ({o.done, o.ack, o.err, o.lat, o.cyc, o.cs} !==
            {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs}) begin
            n_fail++;
            $display("FAIL um_resp: got %h want %h",
                     {o.done, o.ack, o.err, o.lat, o.cyc, o.cs},
                     {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs});
        end
        n_run++;
        if ({o.rd, s_as_u} !== {e.rd, 1'b0}) begin
            n_fail++;
            $display("FAIL um_data: got %h want %h",
                     {o.rd, s_as_u}, {e.rd, 1'b0});
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        int acks = 0, errs = 0, bad = 0, post = 0;
        logic [7:0]  lat = 8'd0;
        logic [31:0] rd  = 32'h0;
        bit seen = 1'b0;
        rdy_after = 3;
        rd_val    = 32'h0000_55AA;
        sb.push_back({1'b1, 1'b0, 8'd4, 8'd3, 8'h02, 32'h0000_55AA, 1'b1});
        issue(1'b0, 32'h2000_0000, 32'h0);
        for (int i = 1; i <= 12; i++) begin
            if (seen && (m_busy_o || cs_a != 8'h0)) post++;
            if (m_busy_o && s_addr_o !== 32'h2000_0000) bad++;
            if (m_err_o) errs++;
            if (m_ack_o) begin
                acks++;
                lat  = 8'(i);
                rd   = m_rd_data_o;
                seen = 1'b1;
            end
            m_req_i     = (i == 2) || m_ack_o;
            m_wr_i      = 1'b1;
            m_addr_i    = 32'hC000_0000;
            m_wr_data_i = 32'hFFFF_0000;
            @(negedge clk_i);
        end
        m_req_i = 1'b0;
        e = sb.pop_front();
        n_run++;
        if ({acks[7:0], errs[7:0], lat, rd} !==
            {8'd1, 8'd0, e.lat, e.rd}) begin
            n_fail++;
            $display("FAIL b2b_resp: got %h want %h",
                     {acks[7:0], errs[7:0], lat, rd},
                     {8'd1, 8'd0, e.lat, e.rd});
        end
        n_run++;
        if ({bad[7:0], post[7:0], s_addr_o} !==
            {8'd0, 8'd0, 32'h2000_0000}) begin
            n_fail++;
            $display("FAIL b2b_ignore: got %h want %h",
                     {bad[7:0], post[7:0], s_addr_o},
                     {8'd0, 8'd0, 32'h2000_0000});
        end
        rdy_after = 1;
        rd_val    = 32'h3333_0001;
        sb.push_back({1'b1, 1'b0, 8'd2, 8'd1, 8'h08, 32'h3333_0001, 1'b1});
        run_access(1'b0, 1'b0, 32'h6000_0000, 32'h0, 20, o);
        e = sb.pop_front();
        n_run++;
        if ({o.done, o.ack, o.err, o.lat, o.cyc, o.cs, o.multi, o.rd} !==
            {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs, 8'd0, e.rd}) begin
            n_fail++;
            $display("FAIL b2b_next: got %h want %h",
                     {o.done, o.ack, o.err, o.lat, o.cyc, o.cs, o.multi, o.rd},
                     {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs, 8'd0, e.rd});
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        int stray = 0;
        rdy_after = 0;
        issue(1'b0, 32'h8000_0000, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        n_run++;
        if ({cs_a, s_as_o, s_wr_o, m_busy_o, m_ack_o, m_err_o,
             s_addr_o, s_wr_data_o, m_rd_data_o} !== 109'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got %h want 0",
                     {cs_a, s_as_o, s_wr_o, m_busy_o, m_ack_o, m_err_o,
                      s_addr_o, s_wr_data_o, m_rd_data_o});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (m_ack_o || m_err_o || m_busy_o) stray++;
        end
        n_run++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL rst_stray: got %0d want 0", stray);
        end
        rdy_after = 2;
        rd_val    = 32'hCAFE_F00D;
        sb.push_back({1'b1, 1'b0, 8'd3, 8'd2, 8'h10, 32'hCAFE_F00D, 1'b1});
        run_access(1'b0, 1'b0, 32'h8000_0008, 32'h0, 20, o);
        e = sb.pop_front();
        n_run++;
        if ({o.done, o.ack, o.err, o.lat, o.cyc, o.cs, o.rd} !==
            {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs, e.rd}) begin
            n_fail++;
            $display("FAIL rst_next: got %h want %h",
                     {o.done, o.ack, o.err, o.lat, o.cyc, o.cs, o.rd},
                     {1'b1, e.ack, e.err, e.lat, e.cyc, e.cs, e.rd});
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        s_rdy_i     = 1'b0;
        s_rd_data_i = '0;
        test_reset();
        test_read_wait();
        test_timeout();
        test_write_zero_wait();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        n_run++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_left: got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
